// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double dabble:
// one right shift plus per-digit "-3 if >= 8" correction per clock.
// Optional invalid-digit detection is enabled by defining BCD_TO_BIN_CHECK_EN.
module bcd_to_bin_seq #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int SR_W  = 4*DIGITS + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   state_t             state;
   state_t             stateNext;
   logic [SR_W-1:0]    sr;
   logic [SR_W-1:0]    srStep;
   logic [CNT_W-1:0]   count;
   logic               lastStep;
   logic               badInput;

   assign lastStep = (count == CNT_W'(BIN_W - 1));

   // One conversion step: shift right, then pull every BCD nibble >= 8 down by 3.
   always_comb begin
      srStep = sr >> 1;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (srStep[BIN_W + 4*d +: 4] >= 4'd8)
            srStep[BIN_W + 4*d +: 4] = srStep[BIN_W + 4*d +: 4] - 4'd3;
      end
   end

`ifdef BCD_TO_BIN_CHECK_EN
   always_comb begin
      badInput = 1'b0;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (bcd_in[4*d +: 4] > 4'd9)
            badInput = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err <= 1'b0;
      else if (state == IDLE && start)
         err <= badInput;
   end
`else
   assign badInput = 1'b0;
   assign err      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (start) stateNext = badInput ? DONE : CONV;
         CONV: if (lastStep) stateNext = DONE;
         DONE: stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr      <= '0;
         count   <= '0;
         bin_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sr    <= {bcd_in, BIN_W'(0)};
                  count <= '0;
                  if (badInput)
                     bin_out <= '0;
               end
            end
            CONV: begin
               sr    <= srStep;
               count <= count + 1'b1;
               if (lastStep)
                  bin_out <= srStep[BIN_W-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed cases plus random valid BCD
// operands checked against a decimal-weighting reference model.
module tb_bcd_to_bin_seq;

   localparam int DIGITS = 3;
   localparam int BIN_W  = 10;
   localparam int LAT    = BIN_W;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 start;
   logic [4*DIGITS-1:0]  bcd_in;
   logic                 busy;
   logic                 done;
   logic [BIN_W-1:0]     bin_out;
   logic                 err;

   int checks = 0;
   int errors = 0;
   int doneCnt = 0;

   bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .bcd_in (bcd_in),
      .busy   (busy),
      .done   (done),
      .bin_out(bin_out),
      .err    (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done) doneCnt <= doneCnt + 1;

   task automatic checkVal(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int refBin(input logic [4*DIGITS-1:0] bcd);
      int sum = 0;
      int weight = 1;
      for (int i = 0; i < DIGITS; i++) begin
         sum += int'(bcd[4*i +: 4]) * weight;
         weight *= 10;
      end
      return sum;
   endfunction

   // Runs one conversion; optional mid-conversion bcd_in change and start pulse.
   task automatic convert(input string tag, input logic [4*DIGITS-1:0] bcd,
                          input logic [4*DIGITS-1:0] midBcd, input bit disturb,
                          input int expBin, input bit expErr, input int expLat);
      int n;
      int prevBin;
      @(negedge clk);
      start  = 1'b1;
      bcd_in = bcd;
      @(negedge clk);
      start = 1'b0;
      checkVal({tag, ".busy"}, busy, 1);
      n = 0;
      while (!done && n < 4*LAT) begin
         if (disturb && n == 3) begin
            bcd_in = midBcd;
            start  = 1'b1;
         end
         if (disturb && n == 4) start = 1'b0;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      checkVal({tag, ".lat"}, n, expLat);
      checkVal({tag, ".bin"}, bin_out, expBin);
      checkVal({tag, ".err"}, err, expErr);
      prevBin = int'(bin_out);
      @(negedge clk);
      checkVal({tag, ".doneLow"}, done, 0);
      checkVal({tag, ".idle"}, busy, 0);
      checkVal({tag, ".hold"}, bin_out, prevBin);
   endtask

   initial begin
      int n;
      int base;
      logic [4*DIGITS-1:0] r;
      rst_n  = 1'b0;
      start  = 1'b0;
      bcd_in = '0;
      repeat (2) @(negedge clk);
      checkVal("rst.busy", busy, 0);
      checkVal("rst.done", done, 0);
      checkVal("rst.bin", bin_out, 0);
      checkVal("rst.err", err, 0);
      rst_n = 1'b1;

      convert("c999", 12'h999, 12'h0, 1'b0, 999, 1'b0, LAT);
      convert("c000", 12'h000, 12'h0, 1'b0, 0, 1'b0, LAT);
      convert("c255", 12'h255, 12'h0, 1'b0, 255, 1'b0, LAT);
      convert("c042mid", 12'h042, 12'h777, 1'b1, 42, 1'b0, LAT);

      // back-to-back with start held high
      @(negedge clk);
      base   = doneCnt;
      start  = 1'b1;
      bcd_in = 12'h512;
      @(negedge clk);
      bcd_in = 12'h001;
      n = 0;
      while (!done && n < 4*LAT) begin
         @(negedge clk);
         n++;
      end
      checkVal("b2b.lat1", n, LAT);
      checkVal("b2b.bin1", bin_out, 512);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 2) start = 1'b0;
      end while (!done && n < 4*LAT);
      start = 1'b0;
      checkVal("b2b.gap", n, LAT + 2);
      checkVal("b2b.bin2", bin_out, 1);
      repeat (4) @(negedge clk);
      checkVal("b2b.count", doneCnt - base, 2);

`ifdef BCD_TO_BIN_CHECK_EN
      convert("bad1A3", 12'h1A3, 12'h0, 1'b0, 0, 1'b1, 0);
      convert("c010", 12'h010, 12'h0, 1'b0, 10, 1'b0, LAT);
`endif

      // reset during a conversion
      @(negedge clk);
      base   = doneCnt;
      start  = 1'b1;
      bcd_in = 12'h999;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkVal("abort.busy", busy, 0);
      checkVal("abort.bin", bin_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2*LAT) @(negedge clk);
      checkVal("abort.noDone", doneCnt - base, 0);
      checkVal("abort.idle", busy, 0);
      convert("c100", 12'h100, 12'h0, 1'b0, 100, 1'b0, LAT);

      for (int k = 0; k < 20; k++) begin
         for (int d = 0; d < DIGITS; d++) r[4*d +: 4] = 4'($urandom_range(9, 0));
         convert("rand", r, 12'h0, k[0], refBin(r), 1'b0, LAT);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential packed-BCD to unsigned-binary converter. It is the inverse of the team's binary-to-BCD (double-dabble) block.
- Uses reverse double dabble: one right shift plus per-digit correction per clock.
- Sits behind BCD keypad/display-style data paths and returns a binary value to arithmetic blocks such as the repeated-add multiplier.
- Start/done handshake; one conversion in flight at a time.

Parameters:
- DIGITS, 3: number of BCD digits in bcd_in; digit 0 is the least significant nibble.
- BIN_W, 10: result width. Must satisfy 2^BIN_W > 10^DIGITS - 1. The pair (3, 10) covers 0..999.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- bcd_in  input  4*DIGITS  packed BCD operand; sampled on the accepting edge only
- busy  output  1  high from the accepting edge until done deasserts
- done  output  1  one-cycle pulse; bin_out and err are valid while it is high
- bin_out  output  BIN_W  converted value; held until the next done
- err  output  1  invalid-digit flag (see Optional Feature); held until the next accepted start

Behaviour:
- Reset (asynchronous on rst_n low):
  - state=IDLE, busy=0, done=0, bin_out=0, err=0, step counter=0, shift register=0.
  - Reset asserted mid-conversion aborts it; no done is produced.
- Internal shift register: SR of width 4*DIGITS+BIN_W, with the BCD field in the upper bits and the binary field in the lower bits.
- States: IDLE, CONV, DONE.
- IDLE:
  - done=0.
  - On an edge with start=1: SR <= {bcd_in, BIN_W'b0}, counter <= 0, err <= 0, busy <= 1, state <= CONV.
  - start=0: remain in IDLE.
- CONV, each edge:
  - SR is logically shifted right by 1.
  - Then each 4-bit BCD field of the shifted value that is >= 8 has 3 subtracted, all digits in parallel in the same cycle.
  - counter increments.
  - On the BIN_W-th CONV edge: bin_out <= final binary field, done <= 1, state <= DONE.
- DONE: lasts one cycle. Next edge: done <= 0, busy <= 0, state <= IDLE.
- Latency:
  - done is high in the cycle following the BIN_W-th edge after the accepting edge (10 cycles at defaults).
  - The next start is accepted 2 edges after done rises, i.e. the back-to-back throughput is one conversion per BIN_W+2 cycles.
- start while busy=1 is ignored. It is neither queued nor does it alter the operation in flight. bcd_in changes during CONV have no effect.
- start held high continuously produces back-to-back conversions, each sampling bcd_in on its own accepting edge.
- bin_out never changes except on a done-setting edge or reset.
- Arithmetic:
  - Zero-extended unsigned throughout.
  - After BIN_W steps the BCD field must be all zeros for valid input. The field is not an output.
  - The subtract never underflows, because corrected nibbles are >= 8.

Optional Feature:
- Macro: BCD_TO_BIN_CHECK_EN.
- Defined:
  - On the accepting edge, any nibble of bcd_in > 9 sets err <= 1 and goes directly to DONE with bin_out <= 0.
  - done follows on the next cycle; latency in this case is 1 edge.
  - Valid inputs are unaffected.
- Undefined:
  - err is tied to 0.
  - Invalid nibbles are converted by the normal algorithm with full BIN_W latency.
  - The result for invalid input is unspecified and not checked.

Test Plan:
- rst_n low, then release; start=1 with bcd_in=12'h999 -> busy=1 the next cycle; done pulses 10 cycles after the accepting edge with bin_out=999 (10'h3E7), err=0.
- bcd_in=12'h000 -> bin_out=0, done after 10 cycles; bcd_in=12'h255 -> bin_out=255.
- start held high with 12'h512 then 12'h001 -> two done pulses 12 cycles apart with bin_out=512 then 1; start pulses during busy are ignored (exactly two done pulses).
- Change bcd_in to 12'h777 mid-conversion of 12'h042 -> bin_out=42.
- With BCD_TO_BIN_CHECK_EN, bcd_in=12'h1A3 -> done on the cycle after acceptance, err=1, bin_out=0; a following start with 12'h010 -> err clears on acceptance and bin_out=10.
- rst_n pulsed low at step 5 of converting 12'h999 -> busy=0, done never pulses, bin_out=0; a subsequent start with 12'h100 -> bin_out=100.
